uart_word_tx: RTL and testbench

Parametrised word serializer between the datapath and the UART transmit FIFO. It captures a WORD_W-bit word on a start pulse and splits it into bytes. Each byte is pushed into the byte-wide TX FIFO with a configurable inter-byte gap and a selectable byte order. It stalls on FIFO full and reports busy and done back to the controller.

---
 rtl/uart_word_tx.sv | 114 +++++++++++
 tb/tb_uart_word_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: splits a captured word into bytes for the UART TX FIFO.
// Define UART_WORD_TX_CSUM_EN to append an XOR checksum byte.
module uart_word_tx #(
  parameter int WORD_W    = 16,
  parameter int GAP_CYC   = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              busy,
  output logic              done,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [7:0]        fifo_wdata
);

  localparam int NBYTES = WORD_W / 8;
`ifdef UART_WORD_TX_CSUM_EN
  localparam int NTOT = NBYTES + 1;
`else
  localparam int NTOT = NBYTES;
`endif
  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NTOT - 1);
  localparam logic [7:0] GLAST =
    8'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE, WRITE, GAP, DONE
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] sh;
  logic [CW-1:0]     bcnt;
  logic [7:0]        gcnt;
  logic [7:0]        tx_byte;
`ifdef UART_WORD_TX_CSUM_EN
  logic [7:0]        csum;
`endif

  always_comb begin
    tx_byte = (MSB_FIRST != 0) ? sh[WORD_W-1 -: 8] : sh[7:0];
`ifdef UART_WORD_TX_CSUM_EN
    // the slot after the data bytes carries the running XOR
    if (bcnt == LAST) tx_byte = csum;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fifo_wr    <= 1'b0;
      fifo_wdata <= 8'h00;
      sh         <= '0;
      bcnt       <= '0;
      gcnt       <= 8'h00;
`ifdef UART_WORD_TX_CSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      fifo_wr <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sh    <= word;
            bcnt  <= '0;
            gcnt  <= 8'h00;
            busy  <= 1'b1;
            state <= WRITE;
`ifdef UART_WORD_TX_CSUM_EN
            csum  <= 8'h00;
`endif
          end
        end
        WRITE: begin
          if (!fifo_full) begin
            fifo_wr    <= 1'b1;
            fifo_wdata <= tx_byte;
            sh <= (MSB_FIRST != 0) ? (sh << 8) : (sh >> 8);
`ifdef UART_WORD_TX_CSUM_EN
            csum <= csum ^ tx_byte;
`endif
            if (bcnt == LAST) begin
              state <= DONE;
            end else begin
              bcnt <= bcnt + 1'b1;
              if (GAP_CYC > 0) state <= GAP;
            end
          end
        end
        GAP: begin
          if (gcnt == GLAST) begin
            gcnt  <= 8'h00;
            state <= WRITE;
          end else begin
            gcnt <= gcnt + 8'h01;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: scoreboard bench over three uart_word_tx configurations.
// Expected bytes and write cycles come from a word-level model.
module tb_uart_word_tx;

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_v [3];
  logic        full_v  [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        wr_v    [3];
  logic [7:0]  wd_v    [3];
  logic [15:0] wa;
  logic [31:0] wb;
  logic [7:0]  wc;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qw [3][$];
  int   qd [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_word_tx #(.WORD_W(16), .GAP_CYC(2), .MSB_FIRST(0)) u_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .word(wa),
    .busy(busy_v[0]), .done(done_v[0]), .fifo_full(full_v[0]),
    .fifo_wr(wr_v[0]), .fifo_wdata(wd_v[0]));

  uart_word_tx #(.WORD_W(32), .GAP_CYC(0), .MSB_FIRST(1)) u_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .word(wb),
    .busy(busy_v[1]), .done(done_v[1]), .fifo_full(full_v[1]),
    .fifo_wr(wr_v[1]), .fifo_wdata(wd_v[1]));

  uart_word_tx #(.WORD_W(8), .GAP_CYC(5), .MSB_FIRST(0)) u_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .word(wc),
    .busy(busy_v[2]), .done(done_v[2]), .fifo_full(full_v[2]),
    .fifo_wr(wr_v[2]), .fifo_wdata(wd_v[2]));

  function automatic int nb(input int id);
    case (id)
      0: return 2;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int gp(input int id);
    case (id)
      0: return 2;
      1: return 0;
      default: return 5;
    endcase
  endfunction

  function automatic bit ms(input int id);
    return id == 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int id);
    exp_t r;
    int   d;
    if (wr_v[id] === 1'b1) begin
      if (qw[id].size() == 0) begin
        chk($sformatf("dut%0d_unexpected_wr", id), 1, 0);
      end else begin
        r = qw[id].pop_front();
        chk($sformatf("dut%0d_wdata", id), int'(wd_v[id]), int'(r.b));
        chk($sformatf("dut%0d_wr_cycle", id), cyc, r.c);
      end
    end
    if (done_v[id] === 1'b1) begin
      if (qd[id].size() == 0) begin
        chk($sformatf("dut%0d_unexpected_done", id), 1, 0);
      end else begin
        d = qd[id].pop_front();
        chk($sformatf("dut%0d_done_cycle", id), cyc, d);
        chk($sformatf("dut%0d_busy_at_done", id), int'(busy_v[id]), 0);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) mon(i);
  end

  task automatic set_word(input int id, input logic [31:0] w);
    case (id)
      0: wa = w[15:0];
      1: wb = w;
      default: wc = w[7:0];
    endcase
  endtask

  // mode 0: no stall, 1: full for 4 attempts, 2: random full
  task automatic send(input int id, input logic [31:0] w,
                      input int mode, input bit xs);
    bit         pat [0:127];
    int         acc, e, lw, dn, n, g, sft;
    logic [7:0] b, cs;
    exp_t       r;
    for (int j = 0; j < 128; j++) begin
      pat[j] = 1'b0;
      if (mode == 1 && j >= 1 && j <= 4) pat[j] = 1'b1;
      if (mode == 2 && j < 40) pat[j] = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    start_v[id] = 1'b1;
    set_word(id, w);
    full_v[id] = pat[0];
    acc = cyc + 1;
    n = nb(id);
    g = gp(id);
    e = acc + 1;
    cs = 8'h00;
    lw = e;
    for (int i = 0; i < n; i++) begin
      sft = ms(id) ? (n - 1 - i) : i;
      b = 8'(w >> (8 * sft));
      cs ^= b;
      while (pat[e - acc]) e++;
      r.b = b;
      r.c = e;
      qw[id].push_back(r);
      lw = e;
      e = e + g + 1;
    end
`ifdef UART_WORD_TX_CSUM_EN
    while (pat[e - acc]) e++;
    r.b = cs;
    r.c = e;
    qw[id].push_back(r);
    lw = e;
`endif
    dn = lw + 1;
    qd[id].push_back(dn);
    for (int j = 1; j <= dn - acc; j++) begin
      @(negedge clk);
      start_v[id] = xs && (j == 2 || j == dn - acc);
      if (j == 1) begin
        chk($sformatf("dut%0d_busy_after_start", id),
            int'(busy_v[id]), 1);
        if (xs) set_word(id, 32'hFFFF_FFFF);
      end
      full_v[id] = pat[j];
    end
    @(negedge clk);
    start_v[id] = 1'b0;
    full_v[id] = 1'b0;
  endtask

  initial begin
    int   acc, id;
    exp_t r;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      full_v[i] = 1'b0;
    end
    wa = '0;
    wb = '0;
    wc = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d_rst_busy", i), int'(busy_v[i]), 0);
      chk($sformatf("dut%0d_rst_done", i), int'(done_v[i]), 0);
      chk($sformatf("dut%0d_rst_wr", i), int'(wr_v[i]), 0);
      chk($sformatf("dut%0d_rst_wdata", i), int'(wd_v[i]), 0);
    end
    reset = 1'b1;
    @(negedge clk);

    send(0, 32'h0000_A55A, 0, 1'b0);
    send(1, 32'h1234_5678, 0, 1'b0);
    send(0, 32'h0000_A55A, 1, 1'b0);
    send(0, 32'h0000_A55A, 0, 1'b1);
    repeat (4) @(negedge clk);

    @(negedge clk);
    start_v[0] = 1'b1;
    wa = 16'hA55A;
    acc = cyc + 1;
    r.b = 8'h5A;
    r.c = acc + 1;
    qw[0].push_back(r);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_v[0]), 0);
    chk("midrst_done", int'(done_v[0]), 0);
    chk("midrst_wr", int'(wr_v[0]), 0);
    chk("midrst_wdata", int'(wd_v[0]), 0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    send(0, 32'h0000_A55A, 0, 1'b0);

    send(2, 32'h0000_003C, 0, 1'b0);

    repeat (30) begin
      id = $urandom_range(0, 2);
      send(id, $urandom, 2, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d_wr_left", i), qw[i].size(), 0);
      chk($sformatf("dut%0d_done_left", i), qd[i].size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
